// File: rtl/split_mux_rr_ctrl.sv
// rtl/split_mux_rr_ctrl.sv - round-robin credit scheduler for a shared split_mux with tag-aligned output id.
// Optional grant/stall counters are enabled by defining SPLIT_MUX_RR_CTRL_PERF_EN.
module split_mux_rr_ctrl #(
  parameter int CNT     = 31,
  parameter int LATENCY = 2,
  parameter int CREDITS = 4,
  parameter int IDW     = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CNT-1:0] req,
  output logic [CNT-1:0] gnt,
  input  logic           mux_vld,
  output logic           out_vld,
  output logic [IDW-1:0] out_id,
  input  logic           crd_rtn,
  output logic [7:0]     crd_cnt,
  output logic           err
`ifdef SPLIT_MUX_RR_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_gnt,
  output logic [31:0]    perf_stall
`endif
);

  logic [CNT-1:0]     r_gnt;
  logic [IDW-1:0]     r_gnt_id;
  logic [IDW-1:0]     r_ptr;
  logic [7:0]         r_crd;
  logic               r_err;
  logic [LATENCY-1:0] r_tag_vld;
  logic [IDW-1:0]     r_tag_id [LATENCY];

  logic [CNT-1:0]     w_eff_req;
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_ptr_nxt;
  logic               w_grant;
  logic               w_crd_full;
  logic               w_rtn_ovf;
  int                 w_idx;

  // Masking the current grant keeps a requester from winning twice while its req falls.
  assign w_eff_req = req & ~r_gnt;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = 0; i < CNT; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= CNT) w_idx = w_idx - CNT;
      if (!w_found && w_eff_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(w_idx);
      end
    end
  end

  assign w_grant    = w_found && (r_crd != 8'd0);
  assign w_ptr_nxt  = (w_win == IDW'(CNT - 1)) ? '0 : w_win + 1'b1;
  assign w_crd_full = (r_crd == 8'(CREDITS));
  assign w_rtn_ovf  = crd_rtn && !w_grant && w_crd_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_ptr     <= '0;
      r_crd     <= 8'(CREDITS);
      r_err     <= 1'b0;
      r_tag_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_gnt    <= w_grant ? (CNT'(1) << w_win) : '0;
      r_gnt_id <= w_grant ? w_win : '0;
      if (w_grant) r_ptr <= w_ptr_nxt;

      if (w_grant && !crd_rtn)
        r_crd <= r_crd - 8'd1;
      else if (!w_grant && crd_rtn && !w_crd_full)
        r_crd <= r_crd + 8'd1;

      r_tag_vld[0] <= |r_gnt;
      r_tag_id[0]  <= r_gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end

      r_err <= r_err | (mux_vld != r_tag_vld[LATENCY-1]) | w_rtn_ovf;
    end
  end

  assign gnt     = r_gnt;
  assign out_vld = r_tag_vld[LATENCY-1];
  assign out_id  = r_tag_id[LATENCY-1];
  assign crd_cnt = r_crd;
  assign err     = r_err;

`ifdef SPLIT_MUX_RR_CTRL_PERF_EN
  logic [31:0] r_perf_gnt;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_gnt   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_grant) r_perf_gnt <= r_perf_gnt + 32'd1;
      if (|w_eff_req && (r_crd == 8'd0)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_gnt   = r_perf_gnt;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_split_mux_rr_ctrl.sv
// tb/tb_split_mux_rr_ctrl.sv - directed scoreboard bench for split_mux_rr_ctrl (CNT=8, LATENCY=2, CREDITS=4).
module tb_split_mux_rr_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       mux_vld;
  logic       out_vld;
  logic [2:0] out_id;
  logic       crd_rtn;
  logic [7:0] crd_cnt;
  logic       err;
`ifdef SPLIT_MUX_RR_CTRL_PERF_EN
  logic [31:0] perf_gnt;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q [$];
  logic [2:0] mon_exp;
  logic       drop;
  logic       m1, m2;

  logic [7:0] rr_gnt [1:7];
  logic [7:0] rr_crd [1:7];
  logic [2:0] rr_id  [1:7];
  logic [7:0] st_crd [1:10];

  split_mux_rr_ctrl #(.CNT(8), .LATENCY(2), .CREDITS(4), .IDW(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .mux_vld(mux_vld),
    .out_vld(out_vld), .out_id(out_id), .crd_rtn(crd_rtn), .crd_cnt(crd_cnt), .err(err)
`ifdef SPLIT_MUX_RR_CTRL_PERF_EN
    , .perf_gnt(perf_gnt), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mux model: dout_vld follows a nonzero sel by two cycles, optionally suppressed by drop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= 1'b0;
      m2 <= 1'b0;
    end else begin
      m1 <= |gnt;
      m2 <= m1;
    end
  end
  assign mux_vld = m2 & ~drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_vld) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        chk("out_id", 32'(out_id), 32'(mon_exp));
      end
    end
  end

  initial begin
    rr_gnt = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00};
    rr_crd = '{8'd3, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
    rr_id  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    st_crd = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    rst_n = 1'b0; req = '0; crd_rtn = 1'b0; drop = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    for (int t = 0; t < 10; t++) begin
      tick();
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_out_vld", 32'(out_vld), 32'd0);
    end
    chk("idle_crd", 32'(crd_cnt), 32'd4);
    chk("idle_err", 32'(err), 32'd0);

    // Three requesters held; credits returned one cycle after each out_vld.
    req = 8'h07;
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(rr_gnt[t]));
      chk("rr_crd", 32'(crd_cnt), 32'(rr_crd[t]));
      if (rr_gnt[t] != 8'h00) exp_q.push_back(rr_id[t]);
      req = (t >= 4) ? 8'h00 : 8'h07;
      crd_rtn = (t >= 3 && t <= 6);
    end
    chk("rr_err", 32'(err), 32'd0);

    // Credit exhaustion with req[5] held.
    req = 8'h20;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("st_gnt", 32'(gnt), ((t % 2 == 1) && t <= 7) ? 32'h20 : 32'h0);
      chk("st_crd", 32'(crd_cnt), 32'(st_crd[t]));
      if ((t % 2 == 1) && t <= 7) exp_q.push_back(3'd5);
    end
    crd_rtn = 1'b1;
    tick();
    chk("st_rtn_gnt", 32'(gnt), 32'd0);
    chk("st_rtn_crd", 32'(crd_cnt), 32'd1);
    crd_rtn = 1'b0;
    tick();
    chk("st_regrant", 32'(gnt), 32'h20);
    chk("st_regrant_crd", 32'(crd_cnt), 32'd0);
    exp_q.push_back(3'd5);
    req = 8'h00;
    tick();
    chk("st_after_gnt", 32'(gnt), 32'd0);
    crd_rtn = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    crd_rtn = 1'b0;
    chk("st_refill_crd", 32'(crd_cnt), 32'd4);
    chk("st_err", 32'(err), 32'd0);

    // Mux drops one dout_vld; err must rise one cycle later and stick.
    req = 8'h04;
    tick();
    chk("dr_gnt", 32'(gnt), 32'h04);
    exp_q.push_back(3'd2);
    req = 8'h00;
    tick();
    chk("dr_err_pre", 32'(err), 32'd0);
    tick();
    chk("dr_out_vld", 32'(out_vld), 32'd1);
    chk("dr_err_pre2", 32'(err), 32'd0);
    drop = 1'b1;
    tick();
    chk("dr_err_set", 32'(err), 32'd1);
    drop = 1'b0;
    crd_rtn = 1'b1;
    tick();
    crd_rtn = 1'b0;
    chk("dr_crd", 32'(crd_cnt), 32'd4);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("dr_err_sticky", 32'(err), 32'd1);
    end

    // Reset with two tags in flight; pointer sits at 6 beforehand so req[7] would win without it.
    req = 8'hB0;
    tick();
    chk("rs_gnt0", 32'(gnt), 32'h10);
    tick();
    chk("rs_gnt1", 32'(gnt), 32'h20);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rs_out_vld", 32'(out_vld), 32'd0);
    chk("rs_gnt", 32'(gnt), 32'd0);
    chk("rs_crd", 32'(crd_cnt), 32'd4);
    chk("rs_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rs_winner", 32'(gnt), 32'h10);
    exp_q.push_back(3'd4);
    req = 8'h00;
    tick(); tick(); tick();
    chk("rs_crd_after", 32'(crd_cnt), 32'd3);
    chk("rs_err_after", 32'(err), 32'd0);

    // Credit overflow.
    crd_rtn = 1'b1;
    tick();
    chk("ov_crd_full", 32'(crd_cnt), 32'd4);
    chk("ov_err_clear", 32'(err), 32'd0);
    tick();
    crd_rtn = 1'b0;
    chk("ov_crd", 32'(crd_cnt), 32'd4);
    chk("ov_err", 32'(err), 32'd1);

    tick(); tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
